alu_ctrl_sequencer: RTL and testbench

Front end that drives the ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes them into ALU SELECT, operand-mux controls and register-file addresses. It holds those controls stable for a per-operation number of wait cycles so the slower multiply and shift paths settle. At completion it issues the register write-enable, or the branch decision taken from the ALU ZERO flag.

---
 rtl/alu_ctrl_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_sequencer.sv
// ALU front-end sequencer: accepts instruction words, decodes ALU controls and holds
// them through a per-op wait window, then pulses register write or branch redirect.
module alu_ctrl_sequencer #(
  parameter int WAIT_MUL   = 2,
  parameter int WAIT_SHIFT = 1,
  parameter int WAIT_BASE  = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  output logic [2:0]  SELECT,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic [2:0]  DEST_ADDR,
  output logic [2:0]  SRC1_ADDR,
  output logic [2:0]  SRC2_ADDR,
  output logic [7:0]  IMM,
  output logic [7:0]  OFFSET,
  output logic        WRITE_EN,
  output logic        TAKE_BRANCH,
  output logic        ILLEGAL,
  output logic        BUSY
);
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_COMP} state_e;
  typedef enum logic [1:0] {BR_NONE, BR_J, BR_EQ, BR_NE} br_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic             imm_sel_q, imm_sel_d, neg_sel_q, neg_sel_d, wr_q, wr_d, ill_q, ill_d;
  br_e              br_q, br_d;
  logic [2:0]       dest_q, dest_d, src1_q, src1_d, src2_q, src2_d;
  logic [7:0]       imm_q, imm_d, off_q, off_d;

  logic [7:0]       opcode;
  logic [2:0]       dec_sel;
  logic             dec_imm, dec_neg, dec_wr, dec_ill;
  br_e              dec_br;
  logic [CNT_W-1:0] dec_wait;
  logic             accept;
  logic             unused_instr;

  assign opcode       = INSTRUCTION[31:24];
  assign unused_instr = ^INSTRUCTION[15:11];

  always_comb begin
    dec_sel  = 3'b000;
    dec_imm  = 1'b0;
    dec_neg  = 1'b0;
    dec_wr   = 1'b0;
    dec_ill  = 1'b0;
    dec_br   = BR_NONE;
    dec_wait = CNT_W'(WAIT_BASE);
    case (opcode)
      8'd0:  begin dec_imm = 1'b1; dec_wr = 1'b1; end
      8'd1:  dec_wr = 1'b1;
      8'd2:  begin dec_sel = 3'b001; dec_wr = 1'b1; end
      8'd3:  begin dec_sel = 3'b001; dec_neg = 1'b1; dec_wr = 1'b1; end
      8'd4:  begin dec_sel = 3'b010; dec_wr = 1'b1; end
      8'd5:  begin dec_sel = 3'b011; dec_wr = 1'b1; end
      8'd6:  dec_br = BR_J;
      8'd7:  begin dec_sel = 3'b001; dec_neg = 1'b1; dec_br = BR_EQ; end
      8'd8:  begin dec_sel = 3'b001; dec_neg = 1'b1; dec_br = BR_NE; end
      8'd9:  begin dec_sel = 3'b110; dec_wr = 1'b1; dec_wait = CNT_W'(WAIT_MUL); end
      8'd10: begin dec_sel = 3'b100; dec_imm = 1'b1; dec_wr = 1'b1; dec_wait = CNT_W'(WAIT_SHIFT); end
      8'd11: begin dec_sel = 3'b101; dec_imm = 1'b1; dec_wr = 1'b1; dec_wait = CNT_W'(WAIT_SHIFT); end
      8'd12: begin dec_sel = 3'b111; dec_imm = 1'b1; dec_wr = 1'b1; dec_wait = CNT_W'(WAIT_SHIFT); end
      default: dec_ill = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      wr_q      <= 1'b0;
      ill_q     <= 1'b0;
      br_q      <= BR_NONE;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      imm_q     <= '0;
      off_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      imm_sel_q <= imm_sel_d;
      neg_sel_q <= neg_sel_d;
      wr_q      <= wr_d;
      ill_q     <= ill_d;
      br_q      <= br_d;
      dest_q    <= dest_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      imm_q     <= imm_d;
      off_q     <= off_d;
    end
  end

  assign accept = IN_VALID && IN_READY;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    imm_sel_d = imm_sel_q;
    neg_sel_d = neg_sel_q;
    wr_d      = wr_q;
    br_d      = br_q;
    dest_d    = dest_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    imm_d     = imm_q;
    off_d     = off_q;
    ill_d     = 1'b0;
    case (state_q)
      S_EXEC: begin
        if (cnt_q == '0) state_d = S_COMP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if (state_q == S_COMP) state_d = S_IDLE;
        if (accept) begin
          dest_d = INSTRUCTION[18:16];
          src1_d = INSTRUCTION[10:8];
          src2_d = INSTRUCTION[2:0];
          imm_d  = INSTRUCTION[7:0];
          off_d  = INSTRUCTION[23:16];
          if (dec_ill) begin
            ill_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            sel_d     = dec_sel;
            imm_sel_d = dec_imm;
            neg_sel_d = dec_neg;
            wr_d      = dec_wr;
            br_d      = dec_br;
            cnt_d     = dec_wait;
            state_d   = S_EXEC;
          end
        end
      end
    endcase
  end

  // Completion pulses are suppressed while RESET is high so a dropped op never commits.
  always_comb begin
    BUSY        = (state_q != S_IDLE);
    IN_READY    = (state_q != S_EXEC);
    SELECT      = BUSY ? sel_q : 3'b000;
    IMM_SEL     = BUSY && imm_sel_q;
    NEG_SEL     = BUSY && neg_sel_q;
    DEST_ADDR   = dest_q;
    SRC1_ADDR   = src1_q;
    SRC2_ADDR   = src2_q;
    IMM         = imm_q;
    OFFSET      = off_q;
    ILLEGAL     = ill_q;
    WRITE_EN    = (state_q == S_COMP) && wr_q && !RESET;
    TAKE_BRANCH = (state_q == S_COMP) && !RESET &&
                  ((br_q == BR_J) || (br_q == BR_EQ && ZERO) || (br_q == BR_NE && !ZERO));
  end
endmodule

// File: tb/tb_alu_ctrl_sequencer.sv
// Directed bench for alu_ctrl_sequencer: inputs change and outputs are checked on the
// falling edge, expected values written by hand from the opcode map and timing.
module tb_alu_ctrl_sequencer;
  logic        CLK = 1'b0;
  logic        RESET, IN_VALID, IN_READY, ZERO;
  logic [31:0] INSTRUCTION;
  logic [2:0]  SELECT, DEST_ADDR, SRC1_ADDR, SRC2_ADDR;
  logic        IMM_SEL, NEG_SEL, WRITE_EN, TAKE_BRANCH, ILLEGAL, BUSY;
  logic [7:0]  IMM, OFFSET;
  int checks = 0;
  int errors = 0;

  alu_ctrl_sequencer #(.WAIT_MUL(2), .WAIT_SHIFT(1), .WAIT_BASE(0)) dut (
    .CLK(CLK), .RESET(RESET), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INSTRUCTION(INSTRUCTION), .ZERO(ZERO), .SELECT(SELECT), .IMM_SEL(IMM_SEL),
    .NEG_SEL(NEG_SEL), .DEST_ADDR(DEST_ADDR), .SRC1_ADDR(SRC1_ADDR),
    .SRC2_ADDR(SRC2_ADDR), .IMM(IMM), .OFFSET(OFFSET), .WRITE_EN(WRITE_EN),
    .TAKE_BRANCH(TAKE_BRANCH), .ILLEGAL(ILLEGAL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  // Present a word for one accept edge; returns in cycle 1 after the accept edge.
  task automatic issue(input logic [31:0] w);
    IN_VALID = 1'b1;
    INSTRUCTION = w;
    tick();
    IN_VALID = 1'b0;
    INSTRUCTION = 32'h0D00_0000;
    #1;
  endtask

  initial begin
    RESET = 1'b1; IN_VALID = 1'b0; ZERO = 1'b0; INSTRUCTION = '0;
    tick(); tick();
    RESET = 1'b0; #1;
    chk("rst_ready", IN_READY, 1); chk("rst_sel", SELECT, 0);
    chk("rst_immsel", IMM_SEL, 0); chk("rst_negsel", NEG_SEL, 0);
    chk("rst_we", WRITE_EN, 0);    chk("rst_tb", TAKE_BRANCH, 0);
    chk("rst_ill", ILLEGAL, 0);    chk("rst_busy", BUSY, 0);
    chk("rst_dest", DEST_ADDR, 0); chk("rst_imm", IMM, 0); chk("rst_off", OFFSET, 0);

    // add
    issue(32'h0204_0201);
    chk("add_c1_sel", SELECT, 3'b001); chk("add_c1_neg", NEG_SEL, 0);
    chk("add_c1_dest", DEST_ADDR, 4);  chk("add_c1_src1", SRC1_ADDR, 2);
    chk("add_c1_src2", SRC2_ADDR, 1);  chk("add_c1_ready", IN_READY, 0);
    chk("add_c1_we", WRITE_EN, 0);     chk("add_c1_busy", BUSY, 1);
    tick();
    chk("add_c2_we", WRITE_EN, 1); chk("add_c2_ready", IN_READY, 1);
    chk("add_c2_sel", SELECT, 3'b001); chk("add_c2_busy", BUSY, 1);
    tick();
    chk("add_c3_we", WRITE_EN, 0); chk("add_c3_busy", BUSY, 0);
    chk("add_c3_sel", SELECT, 0);  chk("add_c3_dest_hold", DEST_ADDR, 4);

    // loadi
    issue(32'h0003_00AB);
    chk("ldi_c1_immsel", IMM_SEL, 1); chk("ldi_c1_imm", IMM, 8'hAB);
    chk("ldi_c1_dest", DEST_ADDR, 3); chk("ldi_c1_sel", SELECT, 0);
    chk("ldi_c1_we", WRITE_EN, 0);
    tick();
    chk("ldi_c2_we", WRITE_EN, 1); chk("ldi_c2_immsel", IMM_SEL, 1);
    tick();
    chk("ldi_c3_we", WRITE_EN, 0); chk("ldi_c3_immsel", IMM_SEL, 0);

    // mult: three EXEC cycles then COMPLETE
    issue(32'h0905_0607);
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("mul_c%0d_sel", i), SELECT, 3'b110);
      chk($sformatf("mul_c%0d_we", i), WRITE_EN, 0);
      chk($sformatf("mul_c%0d_busy", i), BUSY, 1);
      chk($sformatf("mul_c%0d_ready", i), IN_READY, 0);
      tick();
    end
    chk("mul_c4_we", WRITE_EN, 1); chk("mul_c4_sel", SELECT, 3'b110);
    chk("mul_c4_busy", BUSY, 1);   chk("mul_c4_dest", DEST_ADDR, 5);
    tick();
    chk("mul_c5_we", WRITE_EN, 0); chk("mul_c5_busy", BUSY, 0);

    // beq taken
    ZERO = 1'b1;
    issue(32'h07FC_0102);
    chk("beq1_c1_neg", NEG_SEL, 1); chk("beq1_c1_off", OFFSET, 8'hFC);
    chk("beq1_c1_tb", TAKE_BRANCH, 0); chk("beq1_c1_sel", SELECT, 3'b001);
    tick();
    chk("beq1_c2_tb", TAKE_BRANCH, 1); chk("beq1_c2_we", WRITE_EN, 0);
    tick();
    chk("beq1_c3_tb", TAKE_BRANCH, 0);

    // beq not taken
    ZERO = 1'b0;
    issue(32'h07FC_0102);
    tick();
    chk("beq0_c2_tb", TAKE_BRANCH, 0); chk("beq0_c2_we", WRITE_EN, 0);
    tick();

    // bne with ZERO=0 taken, ZERO=1 not taken
    issue(32'h0810_0102);
    chk("bne_c1_neg", NEG_SEL, 1); chk("bne_c1_off", OFFSET, 8'h10);
    tick();
    chk("bne0_c2_tb", TAKE_BRANCH, 1);
    tick();
    ZERO = 1'b1;
    issue(32'h0810_0102);
    tick();
    chk("bne1_c2_tb", TAKE_BRANCH, 0);
    tick();

    // j always taken, never writes
    issue(32'h0620_0000);
    chk("j_c1_sel", SELECT, 0);
    tick();
    chk("j_c2_tb", TAKE_BRANCH, 1); chk("j_c2_we", WRITE_EN, 0);
    tick();
    ZERO = 1'b0;

    // illegal opcode, then add accepted in the pulse cycle
    issue(32'h2000_0000);
    chk("ill_c1_pulse", ILLEGAL, 1); chk("ill_c1_busy", BUSY, 0);
    chk("ill_c1_ready", IN_READY, 1); chk("ill_c1_we", WRITE_EN, 0);
    issue(32'h0207_0605);
    chk("ill_add_c1_ill", ILLEGAL, 0); chk("ill_add_c1_busy", BUSY, 1);
    chk("ill_add_c1_dest", DEST_ADDR, 7);
    tick();
    chk("ill_add_c2_we", WRITE_EN, 1);
    tick();

    // sll with RESET during its second EXEC cycle
    issue(32'h0A01_0203);
    chk("sll_c1_sel", SELECT, 3'b100); chk("sll_c1_immsel", IMM_SEL, 1);
    tick();
    RESET = 1'b1; #1;
    chk("sll_c2_we", WRITE_EN, 0);
    tick();
    RESET = 1'b0; #1;
    chk("sll_c3_we", WRITE_EN, 0); chk("sll_c3_busy", BUSY, 0);
    chk("sll_c3_sel", SELECT, 0);  chk("sll_c3_immsel", IMM_SEL, 0);
    chk("sll_c3_ready", IN_READY, 1); chk("sll_c3_dest", DEST_ADDR, 0);

    // RESET during COMPLETE drops the write
    issue(32'h0201_0203);
    tick();
    RESET = 1'b1; #1;
    chk("rstc_c2_we", WRITE_EN, 0);
    tick();
    RESET = 1'b0; #1;
    chk("rstc_c3_busy", BUSY, 0); chk("rstc_c3_we", WRITE_EN, 0);

    // Back-to-back stream with IN_VALID held; word changes while busy are ignored
    IN_VALID = 1'b1; INSTRUCTION = 32'h0201_0203;
    tick();
    chk("b2b_a_c1_sel", SELECT, 3'b001); chk("b2b_a_c1_dest", DEST_ADDR, 1);
    chk("b2b_a_c1_ready", IN_READY, 0);
    INSTRUCTION = 32'h0502_0304;
    tick();
    chk("b2b_a_c2_we", WRITE_EN, 1); chk("b2b_a_c2_dest", DEST_ADDR, 1);
    tick();
    chk("b2b_b_c1_sel", SELECT, 3'b011); chk("b2b_b_c1_dest", DEST_ADDR, 2);
    chk("b2b_b_c1_we", WRITE_EN, 0);
    INSTRUCTION = 32'h0203_0102;
    tick();
    chk("b2b_b_c2_we", WRITE_EN, 1);
    tick();
    chk("b2b_c_c1_sel", SELECT, 3'b001); chk("b2b_c_c1_dest", DEST_ADDR, 3);
    IN_VALID = 1'b0;
    tick();
    chk("b2b_c_c2_we", WRITE_EN, 1);
    tick();
    chk("b2b_end_busy", BUSY, 0); chk("b2b_end_we", WRITE_EN, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
